// File: rtl/hazard_scoreboard.sv
// Purpose: register-busy scoreboard for an in-order pipeline; detects RAW/WAW/capacity hazards in ID.
// Latency: o_stall/o_issue are combinational (zero cycles); o_pending/o_inflight update on the next edge.
// Backpressure: i_hold blocks issue without stalling; i_flush squashes ID so it neither stalls nor issues.
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int RF_WR_BYPASS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_vld,
  input  logic        i_id_is_rs1,
  input  logic        i_id_is_rs2,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rd_wren,
  input  logic [4:0]  i_id_rd_addr,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_wb_rd_wren,
  input  logic [4:0]  i_wb_rd_addr,
  output logic        o_stall,
  output logic        o_issue,
  output logic [31:0] o_pending,
  output logic [2:0]  o_inflight,
  output logic [31:0] o_stall_cnt,
  output logic        o_err
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);
  localparam logic       BYPASS  = (RF_WR_BYPASS != 0);

  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic [31:0] wb_hit;
  logic [31:0] busy_vec;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        rd_nz;
  logic        wb_nz;
  logic        raw;
  logic        waw;
  logic        full;
  logic        wb_frees;
  logic        set_en;
  logic        clr_en;
  logic        inc;
  logic        dec;
  logic        err_evt;
  logic [2:0]  inflight_d;

  assign o_pending = pending_q;

  // Hazard detection: a register being written back this cycle is not busy when the regfile bypasses.
  always_comb begin
    rd_nz    = (i_id_rd_addr != 5'd0);
    wb_nz    = (i_wb_rd_addr != 5'd0);
    wb_hit   = i_wb_rd_wren ? (32'd1 << i_wb_rd_addr) : 32'd0;
    busy_vec = pending_q & ~(BYPASS ? wb_hit : 32'd0);
    busy_vec[0] = 1'b0;
    raw      = (i_id_is_rs1 & busy_vec[i_id_rs1_addr]) |
               (i_id_is_rs2 & busy_vec[i_id_rs2_addr]);
    waw      = i_id_rd_wren & rd_nz & busy_vec[i_id_rd_addr];
    // A retiring tracked writer frees a slot in the same cycle, so capacity is not a hazard then.
    wb_frees = i_wb_rd_wren & wb_nz & pending_q[i_wb_rd_addr];
    full     = i_id_rd_wren & rd_nz & (o_inflight == MAX_CNT) & ~wb_frees;
    o_stall  = i_id_vld & ~i_flush & (raw | waw | full);
    o_issue  = i_id_vld & ~i_flush & ~i_hold & ~o_stall;
  end

  // Next-state of the busy vector and the in-flight count; a same-register set overrides its clear.
  always_comb begin
    set_en  = o_issue & i_id_rd_wren & rd_nz;
    clr_en  = i_wb_rd_wren & wb_nz;
    set_vec = set_en ? (32'd1 << i_id_rd_addr) : 32'd0;
    clr_vec = clr_en ? (32'd1 << i_wb_rd_addr) : 32'd0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
    inc = set_en;
    dec = clr_en & pending_q[i_wb_rd_addr];
    inflight_d = o_inflight;
    if (inc && !dec) begin
      if (o_inflight != MAX_CNT) inflight_d = o_inflight + 3'd1;
    end else if (!inc && dec) begin
      if (o_inflight != 3'd0) inflight_d = o_inflight - 3'd1;
    end
    // Retiring an untracked register, or re-tracking one that stays busy, breaks the pipeline contract.
    err_evt = (clr_en & ~pending_q[i_wb_rd_addr]) |
              (set_en & pending_q[i_id_rd_addr] & ~(clr_en & (i_wb_rd_addr == i_id_rd_addr)));
  end

  // Scoreboard state, stall statistics and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q   <= 32'd0;
      o_inflight  <= 3'd0;
      o_stall_cnt <= 32'd0;
      o_err       <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      o_inflight <= inflight_d;
      if (o_stall) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (err_evt) o_err <= 1'b1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: MAX_INFLIGHT, 3, max un-retired register writers (1..7).
REQ-002 Parameter: RF_WR_BYPASS, 1, 1 = regfile returns same-cycle WB write data on read; 0 = no write-to-read bypass.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 i_clk  in  1  clock, rising edge.
REQ-005 i_rst  in  1  async active-high reset.
REQ-006 i_id_vld  in  1  valid instruction present in ID.
REQ-007 i_id_is_rs1 / i_id_is_rs2  in  1 each  instruction reads rs1 / rs2.
REQ-008 i_id_rs1_addr / i_id_rs2_addr  in  5 each  ID source registers.
REQ-009 i_id_rd_wren  in  1  instruction writes rd.
REQ-010 i_id_rd_addr  in  5  ID destination register.
REQ-011 i_hold  in  1  downstream stage cannot accept an instruction.
REQ-012 i_flush  in  1  ID instruction is squashed (taken branch).
REQ-013 i_wb_rd_wren  in  1  WB writes regfile this cycle.
REQ-014 i_wb_rd_addr  in  5  WB destination register.
REQ-015 o_stall  out  1  hold PC/IF-ID; insert bubble.
REQ-016 o_issue  out  1  ID instruction accepted into EX this cycle.
REQ-017 o_pending  out  32  registered busy bit per register; bit 0 always 0.
REQ-018 o_inflight  out  3  count of issued, un-retired writers.
REQ-019 o_stall_cnt  out  32  cycles with o_stall=1, wraps at 2^32.
REQ-020 o_err  out  1  sticky protocol-violation flag.

Function
REQ-021 eff_busy(r) = o_pending[r] & ~(RF_WR_BYPASS & i_wb_rd_wren & i_wb_rd_addr==r), for r!=0; eff_busy(0)=0.
REQ-022 raw = (i_id_is_rs1 & eff_busy(rs1)) | (i_id_is_rs2 & eff_busy(rs2)).
REQ-023 waw = i_id_rd_wren & rd!=0 & eff_busy(rd).
REQ-024 full = i_id_rd_wren & rd!=0 & o_inflight==MAX_INFLIGHT & ~(i_wb_rd_wren & o_pending[i_wb_rd_addr] & i_wb_rd_addr!=0).
REQ-025 o_stall = i_id_vld & ~i_flush & (raw | waw | full), combinational, zero latency.
REQ-026 o_issue = i_id_vld & ~i_flush & ~i_hold & ~o_stall.
REQ-027 Set: o_issue & i_id_rd_wren & rd!=0 sets o_pending[rd] at next edge.
REQ-028 Clear: i_wb_rd_wren & wb_addr!=0 clears o_pending[wb_addr] at next edge.
REQ-029 Set and clear of the same register in one cycle: set wins.
REQ-030 o_inflight += set, -= (clear of a bit that was 1); simultaneous set and clear leave it unchanged.
REQ-031 o_inflight never exceeds MAX_INFLIGHT and never underflows.
REQ-032 rd=x0 writers are never tracked; WB to x0 is ignored.
REQ-033 i_flush suppresses stall and issue; no state change from ID that cycle.
REQ-034 o_stall_cnt increments on every cycle where o_stall=1.
REQ-035 o_err sets on either violation: WB write to r!=0 with o_pending[r]=0, or set of an already-pending register. Cleared only by reset.

Reset
REQ-036 i_rst=1 asynchronously forces o_pending=0, o_inflight=0, o_stall_cnt=0, o_err=0, including mid-operation.
REQ-037 o_stall and o_issue follow inputs combinationally during reset, with o_pending=0.
REQ-038 The first edge after deassertion is a normal update.

Verification
REQ-039 Issue addi x5 (rd_wren=1) -> o_pending[5]=1, o_inflight=1. Next cycle add reading rs1=x5 -> o_stall=1, o_issue=0. WB x5 with RF_WR_BYPASS=1 -> o_stall=0 that same cycle.
REQ-040 Same stall scenario, RF_WR_BYPASS=0 -> stall persists through the WB cycle and drops one cycle later; o_stall_cnt is 1 larger than in REQ-039.
REQ-041 Issue writers to x1, x2, x3 (MAX=3), then an x4 writer -> o_stall=1 (full). WB x1 in the same cycle -> o_issue=1 and o_inflight stays 3.
REQ-042 Issue rd=x0 with rs1=x0 -> no stall; o_pending=0; o_inflight=0.
REQ-043 Issue to x7 and WB x7 in the same cycle (x7 previously pending) -> o_pending[7]=1, o_inflight unchanged, o_err=0.
REQ-044 Assert i_rst with x5 and x9 pending -> o_pending=0, o_inflight=0, o_err=0 immediately, without a clock edge. A later WB x5 -> o_err=1.
